// File: rtl/io_bus_arbiter_pkg.sv
// Shared types and constants for the two-master IO bus arbiter.
// Holds the phase-state enum used by the FSM and its debug output.
package io_pkg;

  localparam int IO_ADDR_W  = 8;
  localparam int IO_DATA_W  = 8;
  localparam int NUM_IO_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } io_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Requester handshake plus IO peripheral bus, grouped for the arbiter.
// Handshake: a request transfers in any cycle where i_reqValid[n] and o_reqReady[n] are both high;
// the requester keeps valid and payload stable until then, and o_rspValid[n] is a one-cycle completion pulse.
interface io_bus_arbiter_if;

  logic [io_pkg::NUM_IO_REQ-1:0]                 i_reqValid;
  logic [io_pkg::NUM_IO_REQ-1:0]                 i_reqWrite;
  logic [io_pkg::NUM_IO_REQ*io_pkg::IO_ADDR_W-1:0] i_reqAddress;
  logic [io_pkg::NUM_IO_REQ*io_pkg::IO_DATA_W-1:0] i_reqData;
  logic [io_pkg::NUM_IO_REQ-1:0]                 o_reqReady;
  logic [io_pkg::NUM_IO_REQ-1:0]                 o_rspValid;
  logic [io_pkg::IO_DATA_W-1:0]                  o_rspData;
  logic                                          o_ioSelect;
  logic [io_pkg::IO_ADDR_W-1:0]                  o_ioAddress;
  logic                                          o_ioNOE;
  logic                                          o_ioNWE;
  logic [io_pkg::IO_DATA_W-1:0]                  o_bus;
  logic [io_pkg::IO_DATA_W-1:0]                  i_bus;
  io_pkg::io_state_t                             o_dbgState;

  modport slave (
    input  i_reqValid, i_reqWrite, i_reqAddress, i_reqData, i_bus,
    output o_reqReady, o_rspValid, o_rspData, o_ioSelect, o_ioAddress,
           o_ioNOE, o_ioNWE, o_bus, o_dbgState
  );

  modport master (
    output i_reqValid, i_reqWrite, i_reqAddress, i_reqData, i_bus,
    input  o_reqReady, o_rspValid, o_rspData, o_ioSelect, o_ioAddress,
           o_ioNOE, o_ioNWE, o_bus, o_dbgState
  );

endinterface

// File: rtl/io_rr_arbiter.sv
// Two-way round-robin grant: combinational pick, last winner remembered on accept.
module io_rr_arbiter
  import io_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NUM_IO_REQ-1:0] i_valid,
  input  logic                  i_accept,
  output logic [NUM_IO_REQ-1:0] o_grant,
  output logic                  o_grantIdx
);

  logic r_lastGrant;
  logic w_idx;

  // On contention the requester that did not win last time goes next.
  always_comb begin
    w_idx = 1'b0;
    if (i_valid == 2'b11) begin
      w_idx = ~r_lastGrant;
    end else if (i_valid[1]) begin
      w_idx = 1'b1;
    end
  end

  assign o_grantIdx = w_idx;
  assign o_grant    = (i_valid == 2'b00) ? 2'b00 : (w_idx ? 2'b10 : 2'b01);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_lastGrant <= 1'b1;
    end else if (i_accept) begin
      r_lastGrant <= w_idx;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the 8-bit IO bus between two requesters and runs each request as a
// timed setup / strobe / hold cycle, with every bus-side output registered.
module io_bus_arbiter
  import io_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  io_bus_arbiter_if.slave bus_if
);

  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  io_state_t              r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic                   r_write, w_write;
  logic                   r_gidx, w_gidx;
  logic                   r_sel, w_sel;
  logic [IO_ADDR_W-1:0]   r_ioAddr, w_ioAddr;
  logic [IO_DATA_W-1:0]   r_bus, w_bus;
  logic                   r_noe, w_noe;
  logic                   r_nwe, w_nwe;
  logic [IO_DATA_W-1:0]   r_rdData, w_rdData;
  logic [NUM_IO_REQ-1:0]  r_rspValid, w_rspValid;
  logic [IO_DATA_W-1:0]   r_rspData, w_rspData;

  logic                   w_accept;
  logic [NUM_IO_REQ-1:0]  w_grant;
  logic                   w_grantIdx;
  logic                   w_reqWrite;
  logic [IO_ADDR_W-1:0]   w_reqAddr;
  logic [IO_DATA_W-1:0]   w_reqData;

  assign w_accept = (r_state == ST_IDLE) && (bus_if.i_reqValid != '0);

  io_rr_arbiter u_rr (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_valid    (bus_if.i_reqValid),
    .i_accept   (w_accept),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx)
  );

  assign w_reqWrite = bus_if.i_reqWrite[w_grantIdx];
  assign w_reqAddr  = w_grantIdx ? bus_if.i_reqAddress[IO_ADDR_W +: IO_ADDR_W]
                                 : bus_if.i_reqAddress[0 +: IO_ADDR_W];
  assign w_reqData  = w_grantIdx ? bus_if.i_reqData[IO_DATA_W +: IO_DATA_W]
                                 : bus_if.i_reqData[0 +: IO_DATA_W];

  // Next-state and next-output logic; outputs are computed one phase ahead so they leave registers.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_write    = r_write;
    w_gidx     = r_gidx;
    w_sel      = r_sel;
    w_ioAddr   = r_ioAddr;
    w_bus      = r_bus;
    w_noe      = 1'b1;
    w_nwe      = 1'b1;
    w_rdData   = r_rdData;
    w_rspValid = '0;
    w_rspData  = r_rspData;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state  = ST_SETUP;
          w_cnt    = SETUP_LD;
          w_write  = w_reqWrite;
          w_gidx   = w_grantIdx;
          w_sel    = 1'b1;
          w_ioAddr = w_reqAddr;
          w_bus    = w_reqWrite ? w_reqData : '0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_state = ST_STROBE;
          w_cnt   = STROBE_LD;
          w_noe   = r_write;
          w_nwe   = ~r_write;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (r_cnt == '0) begin
          w_state = ST_HOLD;
          w_cnt   = HOLD_LD;
          if (!r_write) begin
            w_rdData = bus_if.i_bus;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
          w_noe = r_write;
          w_nwe = ~r_write;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state    = ST_IDLE;
          w_sel      = 1'b0;
          w_ioAddr   = '0;
          w_bus      = '0;
          w_rspValid = r_gidx ? 2'b10 : 2'b01;
          w_rspData  = r_write ? '0 : r_rdData;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_gidx     <= 1'b0;
      r_sel      <= 1'b0;
      r_ioAddr   <= '0;
      r_bus      <= '0;
      r_noe      <= 1'b1;
      r_nwe      <= 1'b1;
      r_rdData   <= '0;
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_write    <= w_write;
      r_gidx     <= w_gidx;
      r_sel      <= w_sel;
      r_ioAddr   <= w_ioAddr;
      r_bus      <= w_bus;
      r_noe      <= w_noe;
      r_nwe      <= w_nwe;
      r_rdData   <= w_rdData;
      r_rspValid <= w_rspValid;
      r_rspData  <= w_rspData;
    end
  end

  assign bus_if.o_reqReady  = (r_state == ST_IDLE) ? w_grant : '0;
  assign bus_if.o_rspValid  = r_rspValid;
  assign bus_if.o_rspData   = r_rspData;
  assign bus_if.o_ioSelect  = r_sel;
  assign bus_if.o_ioAddress = r_ioAddr;
  assign bus_if.o_ioNOE     = r_noe;
  assign bus_if.o_ioNWE     = r_nwe;
  assign bus_if.o_bus       = r_bus;
  assign bus_if.o_dbgState  = r_state;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: default-timing instance plus a 2/3/2 timing instance,
// each checked cycle by cycle against a transaction-offset reference model.
module tb_io_bus_arbiter;
  import io_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rst2;

  // ---------------- DUTs ----------------
  io_bus_arbiter_if bus0 ();
  io_bus_arbiter_if bus1 ();

  logic [1:0]  v0, w0, pv, pw;
  logic [15:0] ad0, d0, pad, pd;
  logic [7:0]  ib0, pib;

  assign bus0.i_reqValid   = v0;
  assign bus0.i_reqWrite   = w0;
  assign bus0.i_reqAddress = ad0;
  assign bus0.i_reqData    = d0;
  assign bus0.i_bus        = ib0;
  assign bus1.i_reqValid   = pv;
  assign bus1.i_reqWrite   = pw;
  assign bus1.i_reqAddress = pad;
  assign bus1.i_reqData    = pd;
  assign bus1.i_bus        = pib;

  io_bus_arbiter dut0 (.i_clk(clk), .i_reset(rst), .bus_if(bus0));
  io_bus_arbiter #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2))
    dut1 (.i_clk(clk), .i_reset(rst2), .bus_if(bus1));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] ready;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic       sel;
    logic [7:0] addr;
    logic [7:0] bus;
    logic       noe;
    logic       nwe;
  } obs_t;

  // acc = cycle number of the accepted in-flight transaction, -1 when none.
  typedef struct {
    int         acc;
    int         cyc;
    int         last;
    int         g;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] cap;
  } mdl_t;

  mdl_t m0, m1;
  int checks = 0;
  int failures = 0;

  function automatic void mdl_reset(output mdl_t m);
    m.acc = -1; m.cyc = 0; m.last = 1; m.g = 0;
    m.wr = 1'b0; m.a = '0; m.d = '0; m.cap = '0;
  endfunction

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v[0]) return 0;
    return 1;
  endfunction

  function automatic obs_t mdl_expect(input mdl_t m, input int s, input int p, input int h,
                                      input logic [1:0] valid);
    obs_t e;
    int k, len;
    bit busy, strobe;
    len = s + p + h + 1;
    k = (m.acc < 0) ? -1 : m.cyc - m.acc;
    busy = (k >= 1) && (k < len);
    strobe = (k > s) && (k <= s + p);
    e = '0;
    e.noe = 1'b1;
    e.nwe = 1'b1;
    if (busy) begin
      e.sel = 1'b1;
      e.addr = m.a;
      e.bus = m.wr ? m.d : 8'h00;
    end
    if (strobe) begin
      if (m.wr) e.nwe = 1'b0;
      else e.noe = 1'b0;
    end
    if (k == len) begin
      e.rsp_valid = 2'(1 << m.g);
      e.rsp_data = m.wr ? 8'h00 : m.cap;
    end
    if (!busy && valid != 2'b00) e.ready = 2'(1 << pick(valid, m.last));
    return e;
  endfunction

  function automatic void mdl_update(inout mdl_t m, input int s, input int p, input int h,
                                     input logic r, input logic [1:0] valid, input logic [1:0] wr,
                                     input logic [15:0] addr, input logic [15:0] data,
                                     input logic [7:0] ibus);
    int k, len, g;
    len = s + p + h + 1;
    k = (m.acc < 0) ? -1 : m.cyc - m.acc;
    if (r) begin
      m.acc = -1;
      m.last = 1;
    end else begin
      if (k == s + p && !m.wr) m.cap = ibus;
      if ((k < 1 || k >= len) && valid != 2'b00) begin
        g = pick(valid, m.last);
        m.acc = m.cyc; m.g = g; m.last = g;
        m.wr = wr[g]; m.a = addr[8*g +: 8]; m.d = data[8*g +: 8];
      end
    end
    m.cyc++;
  endfunction

  function automatic obs_t act0();
    obs_t a;
    a.ready = bus0.o_reqReady; a.rsp_valid = bus0.o_rspValid; a.rsp_data = bus0.o_rspData;
    a.sel = bus0.o_ioSelect; a.addr = bus0.o_ioAddress; a.bus = bus0.o_bus;
    a.noe = bus0.o_ioNOE; a.nwe = bus0.o_ioNWE;
    return a;
  endfunction

  function automatic obs_t act1();
    obs_t a;
    a.ready = bus1.o_reqReady; a.rsp_valid = bus1.o_rspValid; a.rsp_data = bus1.o_rspData;
    a.sel = bus1.o_ioSelect; a.addr = bus1.o_ioAddress; a.bus = bus1.o_bus;
    a.noe = bus1.o_ioNOE; a.nwe = bus1.o_ioNWE;
    return a;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t r, a;
    rst = 1'b1; rst2 = 1'b1;
    v0 = '0; w0 = '0; ad0 = '0; d0 = '0; ib0 = '0;
    pv = '0; pw = '0; pad = '0; pd = '0; pib = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    r = '0; r.noe = 1'b1; r.nwe = 1'b1;
    a = act0();
    checks++;
    if (a !== r) begin failures++; $display("FAIL reset0 got=%h exp=%h", a, r); end
    a = act1();
    checks++;
    if (a !== r) begin failures++; $display("FAIL reset1 got=%h exp=%h", a, r); end
    checks++;
    if (bus0.o_dbgState !== ST_IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", bus0.o_dbgState, ST_IDLE);
    end
    mdl_reset(m0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    obs_t e, a;
    int cur, t_acc, rsp_cyc;
    logic [7:0] rsp_d;
    v0 = 2'b01; w0 = 2'b00; ad0 = 16'h0000; d0 = 16'h0000; ib0 = 8'h06;
    t_acc = -1; rsp_cyc = -1; rsp_d = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL read cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      cur = m0.cyc;
      if (e.ready[0]) t_acc = cur;
      if (bus0.o_rspValid[0]) begin rsp_cyc = cur; rsp_d = bus0.o_rspData; end
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      if (e.ready[0]) v0 = 2'b00;
    end
    checks++;
    if (rsp_cyc != t_acc + 5) begin failures++; $display("FAIL read_latency got=%0d exp=%0d", rsp_cyc - t_acc, 5); end
    checks++;
    if (rsp_d !== 8'h06) begin failures++; $display("FAIL read_data got=%h exp=06", rsp_d); end
  endtask

  task automatic test_single_write();
    obs_t e, a;
    int cur, t_acc, rsp_cyc;
    logic [7:0] rsp_d;
    v0 = 2'b10; w0 = 2'b10; ad0 = 16'h0000; d0 = 16'hA500;
    t_acc = -1; rsp_cyc = -1; rsp_d = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      ib0 = 8'($urandom);
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL write cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      cur = m0.cyc;
      if (e.ready[1]) t_acc = cur;
      if (bus0.o_rspValid[1]) begin rsp_cyc = cur; rsp_d = bus0.o_rspData; end
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      if (e.ready[1]) v0 = 2'b00;
    end
    checks++;
    if (rsp_cyc != t_acc + 5) begin failures++; $display("FAIL write_latency got=%0d exp=%0d", rsp_cyc - t_acc, 5); end
    checks++;
    if (rsp_d !== 8'h00) begin failures++; $display("FAIL write_rspdata got=%h exp=00", rsp_d); end
  endtask

  task automatic test_contention();
    obs_t e, a;
    logic [0:0] exp_q[$];
    int last_acc, n_acc, n;
    exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; v0 = 2'b00; last_acc = -1; n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL contention cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      if (e.ready != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL contention_extra got=%b exp=none", a.ready);
        end else begin
          if (a.ready !== 2'(2'b01 << exp_q[0])) begin
            failures++; $display("FAIL contention_grant got=%b exp=%b", a.ready, 2'(2'b01 << exp_q[0]));
          end
          void'(exp_q.pop_front());
        end
        if (last_acc >= 0) begin
          checks++;
          if (m0.cyc - last_acc != 5) begin
            failures++; $display("FAIL contention_gap got=%0d exp=5", m0.cyc - last_acc);
          end
        end
        last_acc = m0.cyc; n_acc++;
      end
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      rst = 1'b0;
      ib0 = 8'($urandom);
      if (i == 0) begin
        v0 = 2'b11; w0 = 2'($urandom); ad0 = 16'($urandom); d0 = 16'($urandom);
      end else if (e.ready != 2'b00) begin
        if (n_acc >= 4) v0 = 2'b00;
        else begin
          n = e.ready[1] ? 1 : 0;
          w0[n] = 1'($urandom); ad0[8*n +: 8] = 8'($urandom); d0[8*n +: 8] = 8'($urandom);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL contention_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_strobe();
    obs_t e, a;
    int cur, t_acc, n_acc;
    v0 = 2'b01; w0 = 2'b01; ad0 = {8'h00, 8'($urandom)}; d0 = {8'h00, 8'($urandom)};
    t_acc = -1; n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      rst = (n_acc == 1) && (m0.cyc == t_acc + 2);
      ib0 = 8'($urandom);
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL rst_mid cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      cur = m0.cyc;
      if (e.ready != 2'b00) begin
        n_acc++;
        if (n_acc == 1) t_acc = cur;
        else if (n_acc == 2) begin
          checks++;
          if (a.ready !== 2'b01) begin failures++; $display("FAIL rst_regrant got=%b exp=01", a.ready); end
        end
      end
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        v0 = 2'b11; w0 = 2'($urandom); ad0 = 16'($urandom); d0 = 16'($urandom);
      end else if (e.ready != 2'b00) begin
        v0 = 2'b00;
      end
    end
    checks++;
    if (n_acc != 2) begin failures++; $display("FAIL rst_accepts got=%0d exp=2", n_acc); end
  endtask

  task automatic test_withdrawn();
    obs_t e, a;
    int cur, t_acc, n_rsp, n_rdy1;
    v0 = 2'b01; w0 = 2'b00; ad0 = {8'($urandom), 8'($urandom)}; d0 = 16'($urandom);
    t_acc = -1; n_rsp = 0; n_rdy1 = 0;
    for (int i = 0; i < 12; i++) begin
      ib0 = 8'($urandom);
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL withdraw cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      cur = m0.cyc;
      if (bus0.o_rspValid != 2'b00) n_rsp++;
      if (bus0.o_reqReady[1]) n_rdy1++;
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      if (e.ready[0]) begin v0[0] = 1'b0; t_acc = cur; end
      v0[1] = (t_acc >= 0) && (m0.cyc == t_acc + 2);
      if (v0[1]) w0[1] = 1'($urandom);
    end
    checks++;
    if (n_rdy1 != 0) begin failures++; $display("FAIL withdraw_ready1 got=%0d exp=0", n_rdy1); end
    checks++;
    if (n_rsp != 1) begin failures++; $display("FAIL withdraw_rsps got=%0d exp=1", n_rsp); end
  endtask

  task automatic test_random();
    obs_t e, a;
    v0 = 2'b00;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      ib0 = 8'($urandom);
      @(negedge clk);
      e = mdl_expect(m0, 1, 2, 1, v0); a = act0();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", m0.cyc, a, e); end
      mdl_update(m0, 1, 2, 1, rst, v0, w0, ad0, d0, ib0);
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (v0[n]) begin
          if (e.ready[n]) v0[n] = 1'b0;
          else if (e.sel && $urandom_range(0, 7) == 0) v0[n] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          v0[n] = 1'b1; w0[n] = 1'($urandom);
          ad0[8*n +: 8] = 8'($urandom); d0[8*n +: 8] = 8'($urandom);
        end
      end
    end
    rst = 1'b0; v0 = 2'b00;
  endtask

  task automatic test_params();
    obs_t e, a;
    int cur, t_acc, noe_cnt, first_low, rsp_cyc;
    logic [7:0] rsp_d, ib_last;
    mdl_reset(m1);
    rst2 = 1'b0;
    pv = 2'b01; pw = 2'b00; pad = 16'h0010; pd = 16'h0000;
    t_acc = -1; noe_cnt = 0; first_low = -1; rsp_cyc = -1; rsp_d = '0; ib_last = '0;
    for (int i = 0; i < 14; i++) begin
      pib = 8'($urandom);
      @(negedge clk);
      e = mdl_expect(m1, 2, 3, 2, pv); a = act1();
      if (e.rsp_valid == 2'b00) a.rsp_data = '0;
      checks++;
      if (a !== e) begin failures++; $display("FAIL params cyc=%0d got=%h exp=%h", m1.cyc, a, e); end
      cur = m1.cyc;
      if (e.ready[0]) t_acc = cur;
      if (!bus1.o_ioNOE) begin noe_cnt++; if (first_low < 0) first_low = cur; end
      if (t_acc >= 0 && cur == t_acc + 5) ib_last = pib;
      if (bus1.o_rspValid[0]) begin rsp_cyc = cur; rsp_d = bus1.o_rspData; end
      mdl_update(m1, 2, 3, 2, rst2, pv, pw, pad, pd, pib);
      @(posedge clk); #1;
      if (e.ready[0]) pv = 2'b00;
    end
    checks++;
    if (noe_cnt != 3) begin failures++; $display("FAIL params_noe_len got=%0d exp=3", noe_cnt); end
    checks++;
    if (first_low != t_acc + 3) begin failures++; $display("FAIL params_noe_start got=%0d exp=%0d", first_low, t_acc + 3); end
    checks++;
    if (rsp_cyc != t_acc + 8) begin failures++; $display("FAIL params_latency got=%0d exp=%0d", rsp_cyc, t_acc + 8); end
    checks++;
    if (rsp_d !== ib_last) begin failures++; $display("FAIL params_data got=%h exp=%h", rsp_d, ib_last); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_reset_mid_strobe();
    test_withdrawn();
    test_random();
    test_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
